seg_scan_n: RTL and testbench

Parametrised multiplexed 7-segment display driver. It converts a binary value to BCD with a sequential shift-add-3 (double-dabble) engine and a load/busy handshake, then time-multiplexes up to 8 common-anode digits. It sits between the game score logic and the board's segment/digit-select pins and supersedes the fixed 4-digit combinational-converter driver.

---
 rtl/seg_scan_n.sv | 188 ++++++++++++++++++
 tb/tb_seg_scan_n.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/seg_scan_n.sv
// seg_scan_n: multiplexed common-anode 7-segment driver with sequential
// binary-to-BCD conversion (shift-add-3) behind a load/busy handshake.
// Optional build macro SEG_LZ_BLANK_EN enables leading-zero blanking.
module seg_scan_n #(
  parameter int unsigned DIGITS   = 4,
  parameter int unsigned BIN_W    = 14,
  parameter int unsigned SCAN_DIV = 24000
) (
  input  logic              clk_24m,
  input  logic              rst_n,
  input  logic [BIN_W-1:0]  bin,
  input  logic              load,
  input  logic [DIGITS-1:0] dp,
  output logic              busy,
  output logic              overflow,
  output logic [7:0]        sm_seg,
  output logic [DIGITS-1:0] sm_bit
);

  localparam int unsigned BCD_W = 4 * DIGITS;
  localparam int unsigned CNT_W = $clog2(BIN_W);
  localparam int unsigned IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int unsigned PRE_W = $clog2(SCAN_DIV);

  function automatic int unsigned pow10(input int unsigned n);
    int unsigned r;
    r = 1;
    for (int unsigned i = 0; i < n; i++) r = r * 10;
    return r;
  endfunction

  localparam int unsigned OVF_LIMIT = pow10(DIGITS);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    COMMIT = 2'd2
  } state_t;

  state_t             state;
  state_t             next_state;
  logic               accept;
  logic               do_shift;
  logic               do_commit;

  logic [BIN_W-1:0]   shreg;
  logic [BCD_W-1:0]   bcd;
  logic [BCD_W-1:0]   bcd_adj;
  logic [BCD_W-1:0]   bcd_next;
  logic [CNT_W-1:0]   bit_cnt;
  logic               ovf_pend;
  logic [BCD_W-1:0]   disp;

  logic [PRE_W-1:0]   presc;
  logic [IDX_W-1:0]   idx;
  logic               tick;
  logic [3:0]         nib;
  logic               dp_sel;
  logic               blank;
  logic               lz;
  logic [7:0]         seg_next;
  logic [DIGITS-1:0]  bit_next;

  // Converter state register
  always_ff @(posedge clk_24m or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= next_state;
  end

  // Converter next-state and datapath strobes
  always_comb begin
    next_state = state;
    accept     = 1'b0;
    do_shift   = 1'b0;
    do_commit  = 1'b0;
    case (state)
      IDLE: begin
        if (load) begin
          accept     = 1'b1;
          next_state = SHIFT;
        end
      end
      SHIFT: begin
        do_shift = 1'b1;
        if (bit_cnt == CNT_W'(BIN_W - 1)) next_state = COMMIT;
      end
      COMMIT: begin
        do_commit  = 1'b1;
        next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  // Add 3 to every BCD nibble >= 5, then shift one binary bit in
  always_comb begin
    bcd_adj = bcd;
    for (int i = 0; i < int'(DIGITS); i++) begin
      if (bcd[i*4 +: 4] >= 4'd5) bcd_adj[i*4 +: 4] = bcd[i*4 +: 4] + 4'd3;
    end
    bcd_next = BCD_W'({bcd_adj, shreg[BIN_W-1]});
  end

  // Conversion datapath, display register and handshake flags
  always_ff @(posedge clk_24m or negedge rst_n) begin
    if (!rst_n) begin
      shreg    <= '0;
      bcd      <= '0;
      bit_cnt  <= '0;
      ovf_pend <= 1'b0;
      disp     <= '0;
      overflow <= 1'b0;
      busy     <= 1'b0;
    end else begin
      busy <= (next_state != IDLE);
      if (accept) begin
        shreg    <= bin;
        bcd      <= '0;
        bit_cnt  <= '0;
        ovf_pend <= (32'(bin) >= OVF_LIMIT);
      end
      if (do_shift) begin
        bcd     <= bcd_next;
        shreg   <= {shreg[BIN_W-2:0], 1'b0};
        bit_cnt <= bit_cnt + CNT_W'(1);
      end
      if (do_commit) begin
        disp     <= bcd;
        overflow <= ovf_pend;
      end
    end
  end

  assign tick = (presc == PRE_W'(SCAN_DIV - 1));

  // Glyph for the digit currently selected by the scan index
  always_comb begin
    nib    = 4'd0;
    dp_sel = 1'b0;
    blank  = 1'b0;
    lz     = 1'b1;
    for (int i = int'(DIGITS) - 1; i >= 0; i--) begin
      lz = lz & (disp[i*4 +: 4] == 4'd0);
      if (idx == IDX_W'(i)) begin
        nib    = disp[i*4 +: 4];
        dp_sel = dp[i];
`ifdef SEG_LZ_BLANK_EN
        blank  = (i != 0) && lz;
`endif
      end
    end
    case (nib)
      4'd0:    seg_next = 8'hC0;
      4'd1:    seg_next = 8'hF9;
      4'd2:    seg_next = 8'hA4;
      4'd3:    seg_next = 8'hB0;
      4'd4:    seg_next = 8'h99;
      4'd5:    seg_next = 8'h92;
      4'd6:    seg_next = 8'h82;
      4'd7:    seg_next = 8'hF8;
      4'd8:    seg_next = 8'h80;
      4'd9:    seg_next = 8'h90;
      default: seg_next = 8'hC0;
    endcase
    if (overflow)   seg_next = 8'hBF;
    else if (blank) seg_next = 8'hFF;
    if (dp_sel)     seg_next[7] = 1'b0;
    bit_next = ~(DIGITS'(1) << idx);
  end

  // Prescaler, scan index and segment/digit output registers
  always_ff @(posedge clk_24m or negedge rst_n) begin
    if (!rst_n) begin
      presc  <= '0;
      idx    <= '0;
      sm_seg <= 8'hFF;
      sm_bit <= '1;
    end else if (tick) begin
      presc  <= '0;
      idx    <= (idx == IDX_W'(DIGITS - 1)) ? '0 : idx + IDX_W'(1);
      sm_seg <= seg_next;
      sm_bit <= bit_next;
    end else begin
      presc <= presc + PRE_W'(1);
    end
  end

endmodule

// File: tb/tb_seg_scan_n.sv
// Directed self-checking bench for seg_scan_n (DIGITS=4, BIN_W=14, SCAN_DIV=4).
`timescale 1ns/1ps
module tb_seg_scan_n;

  localparam int unsigned DIGITS   = 4;
  localparam int unsigned BIN_W    = 14;
  localparam int unsigned SCAN_DIV = 4;

`ifdef SEG_LZ_BLANK_EN
  localparam logic [7:0] LZ = 8'hFF;
`else
  localparam logic [7:0] LZ = 8'hC0;
`endif

  logic              clk_24m;
  logic              rst_n;
  logic [BIN_W-1:0]  bin;
  logic              load;
  logic [DIGITS-1:0] dp;
  logic              busy;
  logic              overflow;
  logic [7:0]        sm_seg;
  logic [DIGITS-1:0] sm_bit;

  int n_assert = 0;
  int n_fail   = 0;
  int blen;

  seg_scan_n #(
    .DIGITS  (DIGITS),
    .BIN_W   (BIN_W),
    .SCAN_DIV(SCAN_DIV)
  ) dut (
    .clk_24m (clk_24m),
    .rst_n   (rst_n),
    .bin     (bin),
    .load    (load),
    .dp      (dp),
    .busy    (busy),
    .overflow(overflow),
    .sm_seg  (sm_seg),
    .sm_bit  (sm_bit)
  );

  initial clk_24m = 1'b0;
  always #5 clk_24m = ~clk_24m;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Request a conversion; returns at the negedge after the accepting edge
  task automatic do_load(input logic [BIN_W-1:0] v);
    bin  = v;
    load = 1'b1;
    @(negedge clk_24m);
    load = 1'b0;
  endtask

  task automatic busy_len(output int n);
    n = 0;
    while (busy && n < 200) begin
      n++;
      @(negedge clk_24m);
    end
  endtask

  task automatic wait_idle(input string tag);
    int n;
    n = 0;
    while (busy && n < 200) begin
      n++;
      @(negedge clk_24m);
    end
    chk({tag, "_idle"}, 32'(busy), 32'd0);
  endtask

  // Sync to the start of a scan frame, then check 16 cycles: 4 digits x 4 cycles each
  task automatic frame(input string tag, input logic [31:0] e);
    logic [3:0] prev;
    logic [3:0] one;
    logic [3:0] eb;
    int n;
    one  = 4'b0001;
    prev = sm_bit;
    n    = 0;
    @(negedge clk_24m);
    while (!(sm_bit == 4'b1110 && prev != 4'b1110) && n < 64) begin
      prev = sm_bit;
      @(negedge clk_24m);
      n++;
    end
    chk({tag, "_sync"}, 32'(sm_bit), 32'h0000000E);
    for (int k = 0; k < 16; k++) begin
      eb = ~(one << (k / 4));
      chk($sformatf("%s_d%0d_c%0d", tag, k / 4, k % 4),
          32'({sm_bit, sm_seg}), 32'({eb, e[(k/4)*8 +: 8]}));
      @(negedge clk_24m);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    load  = 1'b0;
    bin   = '0;
    dp    = '0;
    repeat (3) @(negedge clk_24m);
    rst_n = 1'b1;
    #1;
    chk("rst_seg",  32'(sm_seg),   32'h000000FF);
    chk("rst_bit",  32'(sm_bit),   32'h0000000F);
    chk("rst_busy", 32'(busy),     32'd0);
    chk("rst_ovf",  32'(overflow), 32'd0);
    frame("rst_scan", {LZ, LZ, LZ, 8'hC0});

    // 1234: busy exactly BIN_W+1 cycles, digits 4,3,2,1
    do_load(14'd1234);
    busy_len(blen);
    chk("busy_len_1234", 32'(blen), 32'd15);
    chk("ovf_1234", 32'(overflow), 32'd0);
    frame("d1234", {8'hF9, 8'hA4, 8'hB0, 8'h99});

    // Largest in-range value, first overflowing value, then back to zero
    do_load(14'd9999);
    wait_idle("l9999");
    chk("ovf_9999", 32'(overflow), 32'd0);
    frame("d9999", {8'h90, 8'h90, 8'h90, 8'h90});

    do_load(14'd10000);
    wait_idle("l10000");
    chk("ovf_10000", 32'(overflow), 32'd1);
    frame("d10000", {8'hBF, 8'hBF, 8'hBF, 8'hBF});

    do_load(14'd0);
    wait_idle("l0");
    chk("ovf_0", 32'(overflow), 32'd0);
    frame("d0", {LZ, LZ, LZ, 8'hC0});

    // Leading zeros and a live decimal point on digit 2
    do_load(14'd7);
    wait_idle("l7");
    frame("d7", {LZ, LZ, LZ, 8'hF8});
    dp = 4'b0100;
    frame("d7_dp", {LZ, LZ & 8'h7F, LZ, 8'hF8});
    dp = 4'b0000;

    // Loads during busy are dropped
    do_load(14'd55);
    blen = 0;
    while (busy && blen < 200) begin
      bin  = 14'd99;
      load = 1'b1;
      @(negedge clk_24m);
      blen++;
    end
    load = 1'b0;
    chk("hs_fall", 32'(busy), 32'd0);
    @(negedge clk_24m);
    chk("hs_ignored", 32'(busy), 32'd0);
    frame("d55", {LZ, LZ, 8'h92, 8'h92});

    // Load held across the busy falling cycle starts a new conversion
    do_load(14'd11);
    bin  = 14'd2345;
    load = 1'b1;
    blen = 0;
    while (busy && blen < 200) begin
      @(negedge clk_24m);
      blen++;
    end
    chk("held_gap", 32'(busy), 32'd0);
    @(negedge clk_24m);
    chk("held_reaccept", 32'(busy), 32'd1);
    load = 1'b0;
    wait_idle("l2345");
    frame("d2345", {8'hA4, 8'hB0, 8'h99, 8'h92});

    // Reset in the middle of a conversion
    do_load(14'd321);
    repeat (5) @(negedge clk_24m);
    chk("mid_busy", 32'(busy), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_busy", 32'(busy),   32'd0);
    chk("mid_rst_seg",  32'(sm_seg), 32'h000000FF);
    chk("mid_rst_bit",  32'(sm_bit), 32'h0000000F);
    repeat (5) @(negedge clk_24m);
    rst_n = 1'b1;
    repeat (40) @(negedge clk_24m);
    chk("post_rst_busy", 32'(busy),     32'd0);
    chk("post_rst_ovf",  32'(overflow), 32'd0);
    frame("post_rst", {LZ, LZ, LZ, 8'hC0});

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
